alu_decode_stage: RTL and testbench

- Decode stage that feeds the core's 32-bit ALU: turns RV32I instruction words into the 4-bit alu_op, the two ALU operands and the writeback/branch/memory controls.
- Sits between fetch/register-file read and the ALU/execute stage.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so in_ready is driven from a register.

---
 rtl/alu_decode_stage_pkg.sv | 84 ++++++++
 rtl/alu_decode_stage_imm_gen.sv | 15 +
 rtl/alu_decode_stage.sv | 178 +++++++++++++++++
 tb/tb_alu_decode_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_decode_stage_pkg.sv
// Shared encodings for the RV32I decode stage: ALU op codes, opcodes, funct fields
// and the decoded-entry record carried through the skid buffer.
package alu_decode_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_BNE  = 4'b1011;
  localparam logic [3:0] ALU_BLT  = 4'b1100;
  localparam logic [3:0] ALU_BGE  = 4'b1101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] data_one;
    logic [31:0] data_two;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic [31:0] branch_target;
    logic        illegal;
  } dec_entry_t;

  // alt selects SUB/SRA; callers pass 0 where funct7 has no meaning
  function automatic logic [3:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

  // The ALU shifts by its whole second operand, so only the shamt may survive
  function automatic logic [31:0] shamt_ext(input logic [31:0] v);
    return {27'd0, v[4:0]};
  endfunction

endpackage

// File: rtl/alu_decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction (I, S, B and U formats).
module alu_decode_stage_imm_gen (
  input  logic [31:7] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode stage feeding the ALU, with a valid/ready output register and
// an optional second (skid) entry so in_ready comes straight from a flop.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] data_one,
  output logic [XLEN-1:0] data_two,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            is_branch,
  output logic [XLEN-1:0] branch_target,
  output logic            illegal
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s;
  dec_entry_t  dec_s;
  dec_entry_t  main_r, skid_r;
  logic        main_valid_r, skid_valid_r;
  logic        in_ready_s, in_xfer_s, main_load_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];

  alu_decode_stage_imm_gen u_imm_gen (
    .instr (instr[31:7]),
    .imm_i (imm_i_s),
    .imm_s (imm_s_s),
    .imm_b (imm_b_s),
    .imm_u (imm_u_s)
  );

  // Instruction word to decoded ALU entry
  always_comb begin
    dec_s               = '0;
    dec_s.alu_op        = ALU_ADD;
    dec_s.data_one      = rs1_data;
    dec_s.data_two      = rs2_data;
    dec_s.store_data    = rs2_data;
    dec_s.rd            = instr[11:7];
    case (opcode_s)
      OPC_OP: begin
        if ((funct7_s == F7_BASE) ||
            ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD_SUB) || (funct3_s == F3_SRL_SRA)))) begin
          dec_s.alu_op    = alu_op_from_f3(funct3_s, funct7_s[5]);
          dec_s.reg_write = 1'b1;
          dec_s.data_two  = is_shift_f3(funct3_s) ? shamt_ext(rs2_data) : rs2_data;
        end else begin
          dec_s.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (is_shift_f3(funct3_s)) begin
          if ((funct7_s == F7_BASE) || (funct7_s == F7_ALT)) begin
            dec_s.alu_op    = alu_op_from_f3(funct3_s, funct7_s[5]);
            dec_s.reg_write = 1'b1;
            dec_s.data_two  = shamt_ext(imm_i_s);
          end else begin
            dec_s.illegal = 1'b1;
          end
        end else begin
          dec_s.alu_op    = alu_op_from_f3(funct3_s, 1'b0);
          dec_s.reg_write = 1'b1;
          dec_s.data_two  = imm_i_s;
        end
      end
      OPC_LUI: begin
        dec_s.data_one  = 32'd0;
        dec_s.data_two  = imm_u_s;
        dec_s.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_s.data_one  = pc;
        dec_s.data_two  = imm_u_s;
        dec_s.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        dec_s.data_two  = imm_i_s;
        dec_s.mem_read  = 1'b1;
        dec_s.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec_s.data_two  = imm_s_s;
        dec_s.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec_s.is_branch     = 1'b1;
        dec_s.branch_target = pc + imm_b_s;
        case (funct3_s)
          F3_BEQ:  dec_s.alu_op = ALU_BEQ;
          F3_BNE:  dec_s.alu_op = ALU_BNE;
          F3_BLT:  dec_s.alu_op = ALU_BLT;
          F3_BGE:  dec_s.alu_op = ALU_BGE;
          default: dec_s.illegal = 1'b1;
        endcase
      end
      default: dec_s.illegal = 1'b1;
    endcase
    // Illegal entries still flow downstream but must cause no side effects
    if (dec_s.illegal) begin
      dec_s.alu_op        = ALU_ADD;
      dec_s.reg_write     = 1'b0;
      dec_s.mem_read      = 1'b0;
      dec_s.mem_write     = 1'b0;
      dec_s.is_branch     = 1'b0;
      dec_s.branch_target = 32'd0;
    end else begin
      dec_s.reg_write = dec_s.reg_write && (dec_s.rd != 5'd0);
    end
  end

  assign in_ready_s  = SKID_EN ? !skid_valid_r : (!main_valid_r || out_ready);
  assign in_xfer_s   = in_valid && in_ready_s;
  assign main_load_s = !main_valid_r || out_ready;

  // Main/skid entry registers; a buffered skid entry always refills main first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (main_load_s) begin
      if (skid_valid_r) begin
        main_r       <= skid_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (in_xfer_s) begin
        main_r       <= dec_s;
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
    end else if (in_xfer_s && SKID_EN) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
    end
  end

  assign in_ready      = in_ready_s;
  assign out_valid     = main_valid_r;
  assign alu_op        = main_r.alu_op;
  assign data_one      = main_r.data_one;
  assign data_two      = main_r.data_two;
  assign store_data    = main_r.store_data;
  assign rd            = main_r.rd;
  assign reg_write     = main_r.reg_write;
  assign mem_read      = main_r.mem_read;
  assign mem_write     = main_r.mem_write;
  assign is_branch     = main_r.is_branch;
  assign branch_target = main_r.branch_target;
  assign illegal       = main_r.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage: decode vectors, backpressure,
// flush and asynchronous reset.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [3:0]  alu_op;
  logic [31:0] data_one, data_two, store_data, branch_target;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, is_branch, illegal;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rx [0:7];
  int          n_rx;
  logic        i3_done;

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .data_one(data_one), .data_two(data_two), .store_data(store_data),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .is_branch(is_branch), .branch_target(branch_target), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instr = i; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    #12;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_data_one", data_one, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);             // add x3,x1,x2
    check_val("add_valid", {31'd0, out_valid}, 32'd1);
    check_val("add_op", {28'd0, alu_op}, 32'h0);
    check_val("add_d1", data_one, 32'd5);
    check_val("add_d2", data_two, 32'd7);
    check_val("add_rd", {27'd0, rd}, 32'd3);
    check_val("add_wr", {31'd0, reg_write}, 32'd1);

    issue(32'h40435293, 32'h0, 32'h80000000, 32'h0);      // srai x5,x6,4
    check_val("srai_op", {28'd0, alu_op}, 32'h6);
    check_val("srai_d2", data_two, 32'h00000004);
    check_val("srai_wr", {31'd0, reg_write}, 32'd1);

    issue(32'h003110B3, 32'h0, 32'd1, 32'hFFFFFF21);      // sll x1,x2,x3
    check_val("sll_op", {28'd0, alu_op}, 32'h2);
    check_val("sll_d2", data_two, 32'h00000001);

    issue(32'hFE20CCE3, 32'h100, 32'd3, 32'd4);           // blt x1,x2,-8
    check_val("blt_op", {28'd0, alu_op}, 32'hC);
    check_val("blt_br", {31'd0, is_branch}, 32'd1);
    check_val("blt_wr", {31'd0, reg_write}, 32'd0);
    check_val("blt_tgt", branch_target, 32'h000000F8);
    check_val("blt_d2", data_two, 32'd4);

    issue(32'h0080A203, 32'h0, 32'h1000, 32'h0);          // lw x4,8(x1)
    check_val("lw_op", {28'd0, alu_op}, 32'h0);
    check_val("lw_rd", {31'd0, mem_read}, 32'd1);
    check_val("lw_wr", {31'd0, reg_write}, 32'd1);
    check_val("lw_d2", data_two, 32'd8);

    issue(32'hFE20AE23, 32'h0, 32'h1000, 32'hCAFEBABE);   // sw x2,-4(x1)
    check_val("sw_mw", {31'd0, mem_write}, 32'd1);
    check_val("sw_wr", {31'd0, reg_write}, 32'd0);
    check_val("sw_d2", data_two, 32'hFFFFFFFC);
    check_val("sw_sd", store_data, 32'hCAFEBABE);

    issue(32'h123453B7, 32'h40, 32'h99, 32'h0);           // lui x7,0x12345
    check_val("lui_d1", data_one, 32'd0);
    check_val("lui_d2", data_two, 32'h12345000);

    issue(32'h00208033, 32'h0, 32'd1, 32'd2);             // add x0,x1,x2
    check_val("x0_wr", {31'd0, reg_write}, 32'd0);

    issue(32'h0020F063, 32'h0, 32'd1, 32'd2);             // bgeu
    check_val("bgeu_valid", {31'd0, out_valid}, 32'd1);
    check_val("bgeu_ill", {31'd0, illegal}, 32'd1);
    check_val("bgeu_br", {31'd0, is_branch}, 32'd0);
    check_val("bgeu_op", {28'd0, alu_op}, 32'h0);

    issue(32'h008000EF, 32'h0, 32'd1, 32'd2);             // jal x1
    check_val("jal_valid", {31'd0, out_valid}, 32'd1);
    check_val("jal_ill", {31'd0, illegal}, 32'd1);
    check_val("jal_flags", {28'd0, reg_write, mem_read, mem_write, is_branch}, 32'd0);

    @(posedge clk); #1;
    check_val("idle_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: three back-to-back adds tagged by rs1_data
    @(negedge clk);
    out_ready = 1'b0; instr = 32'h002081B3; rs1_data = 32'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    check_val("bp1_ready", {31'd0, in_ready}, 32'd1);
    check_val("bp1_d1", data_one, 32'h11);
    @(negedge clk);
    rs1_data = 32'h22;
    @(posedge clk); #1;
    check_val("bp2_ready", {31'd0, in_ready}, 32'd0);
    check_val("bp2_hold", data_one, 32'h11);
    @(negedge clk);
    rs1_data = 32'h33;
    @(posedge clk); #1;
    check_val("bp3_hold", data_one, 32'h11);
    check_val("bp3_valid", {31'd0, out_valid}, 32'd1);

    n_rx = 0;
    i3_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = !i3_done;
      #1;
      if (out_valid && out_ready && n_rx < 8) begin
        rx[n_rx] = data_one;
        n_rx++;
      end
      if (in_valid && in_ready) i3_done = 1'b1;
      @(posedge clk);
    end
    in_valid = 1'b0;
    check_val("drain_count", n_rx, 32'd3);
    check_val("drain_0", rx[0], 32'h11);
    check_val("drain_1", rx[1], 32'h22);
    check_val("drain_2", rx[2], 32'h33);

    // Flush with both entries full and a new input in the same cycle
    @(negedge clk);
    out_ready = 1'b0; rs1_data = 32'h44; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rs1_data = 32'h55;
    @(posedge clk); #1;
    check_val("fl_full", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b1; rs1_data = 32'h66;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl_valid", {31'd0, out_valid}, 32'd0);
    check_val("fl_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check_val("fl_discard", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stream
    issue(32'h002081B3, 32'h0, 32'h77, 32'h0);
    check_val("ar_pre", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("ar_valid", {31'd0, out_valid}, 32'd0);
    check_val("ar_d1", data_one, 32'd0);
    check_val("ar_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
